display_cycler: RTL
===================

// Module: display_cycler
// PURPOSE
//   Drives the `selector` input of the display mux. The mux selects the water-level view
//   when selector=0 and the irrigation view when selector=1.
//   Normally alternates between the two views on a fixed dwell time.
//   A debounced button press switches the view immediately.
//   An active alarm forces the water view and produces a blink/blank signal for the display.
// PARAMETERS
//   TICK_DIV        50000  clock cycles per base tick (1 kHz at 50 MHz); >=2
//   DWELL_TICKS     2000   ticks each view is held before auto-switch; >=1
//   BLINK_TICKS     250    ticks per blank on/off half-period while in alarm; >=1
//   DEBOUNCE_TICKS  20     consecutive ticks the button must be stable before it is accepted; >=1
//   Counter widths are $clog2(param) each, minimum 1 bit.
// PORTS
//   clock     in   1  system clock; all logic on its rising edge
//   reset     in   1  synchronous, active-high
//   alarm     in   1  level; 1 = critical condition (already synchronous to clock)
//   button    in   1  raw, asynchronous push-button; 1 = pressed
//   selector  out  1  registered; 0 = water view, 1 = irrigation view
//   blank     out  1  registered; 1 = display must be blanked (alarm blink)
//   switched  out  1  registered; one-cycle pulse on every selector change
// BEHAVIOUR
//   Reset (sampled at a rising edge)
//   - Next state is WATER.
//   - selector, blank and switched are all 0.
//   - All counters, both synchronizer flops and the debounced level are 0.
//   - Reset overrides every other input, including mid-alarm and mid-debounce.
//   Tick generator
//   - tdiv counts 0..TICK_DIV-1 and then wraps to 0.
//   - tick=1 for exactly one cycle when tdiv==TICK_DIV-1.
//   Button path
//   - Two-flop synchronizer produces btn_s.
//   - On a tick where btn_s != deb_level, stable_cnt increments; on a tick where they are
//     equal, stable_cnt clears to 0.
//   - When stable_cnt reaches DEBOUNCE_TICKS, deb_level <= btn_s and stable_cnt clears.
//   - press is a 1-cycle pulse on the 0->1 transition of deb_level. Release produces no event.
//   FSM (states WATER, IRRIGATION, ALARM; evaluated every cycle, priority from top down)
//   - alarm=1 -> ALARM, from any state.
//   - In ALARM with alarm=0 -> WATER; dwell and blink counters clear, blank <= 0.
//   - In WATER/IRRIGATION, press OR (tick AND dwell==DWELL_TICKS-1) -> the other view,
//     and dwell clears.
//     If both conditions hold in the same cycle, the view switches exactly once.
//   - Otherwise dwell increments on each tick.
//   Outputs
//   - selector = (state==IRRIGATION). It is registered, so it changes 1 cycle after the
//     triggering condition.
//   - In ALARM, blank starts at 0 on entry and toggles after every BLINK_TICKS ticks.
//     blank is 0 in all other states.
//   - In ALARM, presses are consumed and discarded; dwell is frozen at 0.
//   - switched=1 in the cycle selector changes value.
//     IRRIGATION->ALARM pulses switched; WATER->ALARM and ALARM->WATER do not.
//   - dwell and blink counters wrap to 0 on reaching their limit; they never exceed
//     limit-1.
// TESTING  (TICK_DIV=4, DWELL_TICKS=3, BLINK_TICKS=2, DEBOUNCE_TICKS=2)
//   1. Reset, then idle inputs:
//      - selector is 0 for 12 cycles, then 1 for 12 cycles, repeating.
//      - switched pulses for 1 cycle at each change.
//   2. Button held high for 3 ticks in WATER:
//      - Exactly one switch to selector=1; dwell restarts.
//      A 1-tick button glitch causes no switch.
//   3. Debounced press in the same cycle as a dwell expiry:
//      - selector toggles once, switched pulses once.
//   4. alarm=1 while in IRRIGATION:
//      - Next cycle selector=0 and switched=1.
//      - blank toggles 0/1 every 8 cycles; presses are ignored.
//      Then alarm=0:
//      - Next cycle state is WATER with blank=0; the next auto-switch is 12 cycles later.
//   5. reset=1 mid-ALARM with blank=1 and mid-debounce:
//      - Next edge gives selector=0, blank=0, switched=0.
//      - The first auto-switch comes 12 cycles after reset is released.

Source files
------------

// File: rtl/display_cycler_if.sv
// Signal bundle between the display cycler and its surroundings: alarm and
// button come in, selector/blank/switched and the FSM state go out.
interface display_cycler_if;
    logic       alarm;
    logic       button;
    logic       selector;
    logic       blank;
    logic       switched;
    logic [1:0] dbg_state;

    modport master (
        output alarm,
        output button,
        input  selector,
        input  blank,
        input  switched,
        input  dbg_state
    );

    modport slave (
        input  alarm,
        input  button,
        output selector,
        output blank,
        output switched,
        output dbg_state
    );
endinterface

// File: rtl/display_cycler.sv
// Alternates the display mux between water and irrigation views, switches on a
// debounced button press, and forces a blinking water view while alarm is high.
module display_cycler #(
    parameter int TICK_DIV       = 50000,
    parameter int DWELL_TICKS    = 2000,
    parameter int BLINK_TICKS    = 250,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic              clock,
    input  logic              reset,
    display_cycler_if.slave   io_disp
);

    localparam int TD_W = (TICK_DIV > 1)       ? $clog2(TICK_DIV)       : 1;
    localparam int DW_W = (DWELL_TICKS > 1)    ? $clog2(DWELL_TICKS)    : 1;
    localparam int BL_W = (BLINK_TICKS > 1)    ? $clog2(BLINK_TICKS)    : 1;
    localparam int DB_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

    typedef enum logic [1:0] {
        S_WATER      = 2'd0,
        S_IRRIGATION = 2'd1,
        S_ALARM      = 2'd2
    } state_t;

    logic [TD_W-1:0] r_tdiv;
    logic            w_tick;

    assign w_tick = (r_tdiv == TD_W'(TICK_DIV - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tdiv <= '0;
        end else if (w_tick) begin
            r_tdiv <= '0;
        end else begin
            r_tdiv <= r_tdiv + TD_W'(1);
        end
    end

    logic            r_sync1;
    logic            r_sync2;
    logic            r_deb_level;
    logic [DB_W-1:0] r_stable;
    logic            w_btn_s;
    logic            w_accept;
    logic            w_press;

    // The count never stores DEBOUNCE_TICKS itself: the tick that would reach
    // it accepts the new level directly, and that same cycle carries the press.
    assign w_btn_s  = r_sync2;
    assign w_accept = w_tick && (w_btn_s != r_deb_level) &&
                      (r_stable == DB_W'(DEBOUNCE_TICKS - 1));
    assign w_press  = w_accept && w_btn_s;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_deb_level <= 1'b0;
            r_stable    <= '0;
        end else begin
            r_sync1 <= io_disp.button;
            r_sync2 <= r_sync1;
            if (w_tick) begin
                if (w_btn_s != r_deb_level) begin
                    if (w_accept) begin
                        r_deb_level <= w_btn_s;
                        r_stable    <= '0;
                    end else begin
                        r_stable <= r_stable + DB_W'(1);
                    end
                end else begin
                    r_stable <= '0;
                end
            end
        end
    end

    state_t          r_state;
    state_t          w_state_next;
    logic [DW_W-1:0] r_dwell;
    logic [DW_W-1:0] w_dwell_next;
    logic [BL_W-1:0] r_blink;
    logic [BL_W-1:0] w_blink_next;
    logic            r_blank;
    logic            w_blank_next;
    logic            r_selector;
    logic            r_switched;
    logic            w_selector_next;

    always_comb begin
        w_state_next = r_state;
        w_dwell_next = r_dwell;
        w_blink_next = r_blink;
        w_blank_next = r_blank;
        if (io_disp.alarm) begin
            w_state_next = S_ALARM;
            w_dwell_next = '0;
            if (r_state != S_ALARM) begin
                w_blink_next = '0;
                w_blank_next = 1'b0;
            end else if (w_tick) begin
                if (r_blink == BL_W'(BLINK_TICKS - 1)) begin
                    w_blink_next = '0;
                    w_blank_next = ~r_blank;
                end else begin
                    w_blink_next = r_blink + BL_W'(1);
                end
            end
        end else if (r_state == S_ALARM) begin
            w_state_next = S_WATER;
            w_dwell_next = '0;
            w_blink_next = '0;
            w_blank_next = 1'b0;
        end else begin
            w_blink_next = '0;
            w_blank_next = 1'b0;
            // A press coinciding with dwell expiry still flips the view only once.
            if (w_press || (w_tick && (r_dwell == DW_W'(DWELL_TICKS - 1)))) begin
                w_state_next = (r_state == S_WATER) ? S_IRRIGATION : S_WATER;
                w_dwell_next = '0;
            end else if (w_tick) begin
                w_dwell_next = r_dwell + DW_W'(1);
            end
        end
        w_selector_next = (w_state_next == S_IRRIGATION);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_WATER;
            r_dwell    <= '0;
            r_blink    <= '0;
            r_blank    <= 1'b0;
            r_selector <= 1'b0;
            r_switched <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_dwell    <= w_dwell_next;
            r_blink    <= w_blink_next;
            r_blank    <= w_blank_next;
            r_selector <= w_selector_next;
            r_switched <= (w_selector_next != r_selector);
        end
    end

    assign io_disp.selector  = r_selector;
    assign io_disp.blank     = r_blank;
    assign io_disp.switched  = r_switched;
    assign io_disp.dbg_state = r_state;

endmodule
